// File: rtl/starter_rx_fifo_if.sv
// Bundle of the starter receive FIFO data, status and control signals.
// master drives the input stream and consumer ready; slave is the FIFO itself.
interface starter_rx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int LVL_W  = 5,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic [CNT_W-1:0]  drop_cnt;
    logic              clr_ovf;

    modport master (
        output in_valid, in_data, out_ready, clr_ovf,
        input  out_valid, out_data, level, overflow, drop_cnt
    );

    modport slave (
        input  in_valid, in_data, out_ready, clr_ovf,
        output out_valid, out_data, level, overflow, drop_cnt
    );
endinterface

// File: rtl/starter_rx_fifo.sv
// Circular receive FIFO for the starter byte stream: no input backpressure,
// first-word fall-through valid/ready output, sticky overflow and saturating drop count.
module starter_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 8
) (
    input logic               clk,
    input logic               rst_n,
    starter_rx_fifo_if.slave  io_bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [LW-1:0]     r_wr_ptr;
    logic [LW-1:0]     r_rd_ptr;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [LW-1:0]     w_level;

    // Extra pointer MSB distinguishes full from empty when the address bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_pop   = !w_empty && io_bus.out_ready;
    assign w_push  = io_bus.in_valid && (!w_full || w_pop);
    assign w_drop  = io_bus.in_valid && w_full && !w_pop;
    assign w_level = r_wr_ptr - r_rd_ptr;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= io_bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // A drop in the clearing cycle is counted after the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (io_bus.clr_ovf) begin
                r_drop_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (r_drop_cnt != {CNT_W{1'b1}}) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end else if (io_bus.clr_ovf) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign io_bus.out_valid = !w_empty;
    assign io_bus.out_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign io_bus.level     = w_level;
    assign io_bus.overflow  = r_ovf;
    assign io_bus.drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_starter_rx_fifo.sv
// Directed bench for starter_rx_fifo; accepted bytes go into a scoreboard queue
// and a negedge monitor checks every popped byte against it.
module tb_starter_rx_fifo;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 8;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic clk;
    logic rst_n;

    starter_rx_fifo_if #(.DATA_W(DATA_W), .LVL_W(LVL_W), .CNT_W(CNT_W)) bus ();

    starter_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DATA_W-1:0] sb_q[$];
    int m_lvl = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every pop seen on the port must match the oldest accepted byte.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                check("pop_with_empty_scoreboard", 32'd1, 32'd0);
            end else begin
                check("pop_data", {24'd0, bus.out_data}, {24'd0, sb_q.pop_front()});
            end
        end
    end

    // One clock cycle of stimulus; ends 1 time unit after the rising edge.
    task automatic cyc(input bit v, input logic [DATA_W-1:0] d, input bit rdy, input bit clr);
        bit pop, push;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = rdy;
        bus.clr_ovf   = clr;
        pop  = rdy && (m_lvl > 0);
        push = v && ((m_lvl < DEPTH) || pop);
        if (push) sb_q.push_back(d);
        m_lvl = m_lvl + int'(push) - int'(pop);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.clr_ovf   = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.clr_ovf   = 1'b0;
        rst_n = 1'b0;
        #23;
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1
        cyc(1, 8'h11, 0, 0);
        check("t1_first_visible", 32'(bus.out_valid), 32'd1);
        cyc(1, 8'h22, 0, 0);
        cyc(1, 8'h33, 0, 0);
        check("t1_level", 32'(bus.level), 32'd3);
        check("t1_head", 32'(bus.out_data), 32'h11);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 0);
        check("t1_head_stable", 32'(bus.out_data), 32'h11);
        check("t1_valid_stable", 32'(bus.out_valid), 32'd1);

        // T2
        for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 0);
        check("t2_level", 32'(bus.level), 32'd0);
        check("t2_out_valid", 32'(bus.out_valid), 32'd0);
        check("t2_out_data", 32'(bus.out_data), 32'd0);
        cyc(0, 8'h00, 1, 0);
        check("t2_ready_while_empty", 32'(bus.level), 32'd0);

        // T3
        for (int i = 0; i < 20; i++) cyc(1, 8'(i), 0, 0);
        check("t3_level", 32'(bus.level), 32'd16);
        check("t3_overflow", 32'(bus.overflow), 32'd1);
        check("t3_drop_cnt", 32'(bus.drop_cnt), 32'd4);
        check("t3_head", 32'(bus.out_data), 32'h00);

        // T4
        cyc(1, 8'hAA, 1, 0);
        check("t4_level", 32'(bus.level), 32'd16);
        check("t4_no_drop", 32'(bus.drop_cnt), 32'd4);
        check("t4_new_head", 32'(bus.out_data), 32'h01);

        // T5
        for (int i = 0; i < 300; i++) cyc(1, 8'hEE, 0, 0);
        check("t5_saturated", 32'(bus.drop_cnt), 32'd255);
        check("t5_overflow", 32'(bus.overflow), 32'd1);
        cyc(0, 8'h00, 0, 1);
        check("t5_clr_overflow", 32'(bus.overflow), 32'd0);
        check("t5_clr_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        cyc(1, 8'h55, 0, 1);
        check("t5_clr_drop_overflow", 32'(bus.overflow), 32'd1);
        check("t5_clr_drop_cnt", 32'(bus.drop_cnt), 32'd1);
        check("t5_level_kept", 32'(bus.level), 32'd16);
        for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0);
        check("t5_drained", 32'(bus.level), 32'd0);

        // T6
        for (int i = 0; i < 7; i++) cyc(1, 8'h60 + 8'(i), 0, 0);
        check("t6_level_before", 32'(bus.level), 32'd7);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        m_lvl = 0;
        #1;
        check("t6_async_level", 32'(bus.level), 32'd0);
        check("t6_async_valid", 32'(bus.out_valid), 32'd0);
        check("t6_async_data", 32'(bus.out_data), 32'd0);
        check("t6_async_overflow", 32'(bus.overflow), 32'd0);
        check("t6_async_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        @(posedge clk);
        #1;
        check("t6_in_ignored_in_reset", 32'(bus.level), 32'd0);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1, 8'hA5, 0, 0);
        check("t6_post_reset_data", 32'(bus.out_data), 32'hA5);
        check("t6_post_reset_level", 32'(bus.level), 32'd1);
        cyc(0, 8'h00, 1, 0);
        check("t6_final_level", 32'(bus.level), 32'd0);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
